// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: words arrive over valid/ready, queue in a small FIFO and
// leave one bit per clock on ser_out. Macro SER_LSB_FIRST_EN selects LSB-first order.
module seq_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic                   ser_out,
    output logic                   ser_active,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] shifter_q, shifter_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    logic full, empty, push, pop;

    // Handshake: a word is taken on any edge where din_valid && din_ready; din_ready
    // comes only from the registered level, so it never depends on din_valid.
    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign push  = din_valid && !full;
    // Level is the pre-edge value, so a word pushed while idle is popped one edge later.
    assign pop   = !empty && ((state_q == IDLE) || (bit_cnt_q == LAST_BIT));

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        state_d   = state_q;
        shifter_d = shifter_q;
        bit_cnt_d = bit_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = SHIFT;
                    shifter_d = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != LAST_BIT) begin
`ifdef SER_LSB_FIRST_EN
                    shifter_d = {1'b0, shifter_q[WIDTH-1:1]};
`else
                    shifter_d = {shifter_q[WIDTH-2:0], 1'b0};
`endif
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end else if (pop) begin
                    shifter_d = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                end else begin
                    // Clearing the shifter keeps the line at 0 while idle.
                    state_d   = IDLE;
                    shifter_d = '0;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            shifter_q <= '0;
            bit_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            shifter_q <= shifter_d;
            bit_cnt_q <= bit_cnt_d;
            mem_q     <= mem_d;
        end
    end

    assign din_ready  = !full;
    assign ser_active = (state_q == SHIFT);
    assign fifo_level = level_q;
`ifdef SER_LSB_FIRST_EN
    assign ser_out = shifter_q[0];
`else
    assign ser_out = shifter_q[WIDTH-1];
`endif

endmodule
